// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC multiplexed-bus burst master.
// The strobe pattern of each FSM state lives here so it is defined in exactly one place.
package rtc_bus_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AS_HI,
        S_AS_LO,
        S_CS_SU,
        S_STROBE,
        S_CS_HOLD,
        S_RECOVER,
        S_DONE
    } state_e;

    typedef struct packed {
        logic ad;
        logic wr;
        logic rd;
        logic cs;
        logic oe;
    } strb_t;

    localparam int DEF_NREG  = 3;
    localparam int DEF_DW    = 8;
    localparam int DEF_T_AS  = 2;
    localparam int DEF_T_AH  = 2;
    localparam int DEF_T_PW  = 4;
    localparam int DEF_T_REC = 4;
    localparam int TMR_W     = 8;

    localparam logic [7:0] RTC_ADDR_HOUR = 8'h43;
    localparam logic [7:0] RTC_ADDR_MIN  = 8'h42;
    localparam logic [7:0] RTC_ADDR_SEC  = 8'h41;

    // Pin levels while sitting in state s; rd and wr are never low together,
    // and the bus is released whenever rd can be low.
    function automatic strb_t strobes_for(state_e s, logic rnw);
        strb_t v;
        // NOTE: blocking '=' is right for locals in functions and combinational
        // code; registered state is only ever written with '<=' in always_ff.
        v = '{ad: 1'b1, wr: 1'b1, rd: 1'b1, cs: 1'b1, oe: 1'b0};
        case (s)
            S_AS_HI:            v.oe = 1'b1;
            S_AS_LO:            begin v.ad = 1'b0; v.oe = 1'b1; end
            S_CS_SU, S_CS_HOLD: begin v.ad = 1'b0; v.cs = 1'b0; v.oe = !rnw; end
            S_STROBE: begin
                v.ad = 1'b0;
                v.cs = 1'b0;
                v.oe = !rnw;
                v.wr = rnw;
                v.rd = !rnw;
            end
            default: ;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/rtc_bus_if.sv
// Pin-level bundle between the burst master and the RTC chip pads.
interface rtc_bus_if #(
    parameter int DW = 8
);
    logic [DW-1:0] ad_out;
    logic          ad_oe;
    logic [DW-1:0] ad_in;
    logic          ad;
    logic          wr;
    logic          rd;
    logic          cs;

    modport master (output ad_out, ad_oe, ad, wr, rd, cs, input ad_in);
    modport slave  (input ad_out, ad_oe, ad, wr, rd, cs, output ad_in);
endinterface

// File: rtl/rtc_phase_timer.sv
// Loadable down counter with a zero flag; sets the length of every timed FSM phase.
module rtc_phase_timer #(
    parameter int TW = 8
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_load,
    input  logic [TW-1:0] i_value,
    output logic          o_zero
);
    logic [TW-1:0] r_count;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - TW'(1);
        end
    end

    assign o_zero = (r_count == '0);
endmodule

// File: rtl/rtc_bus_master.sv
// Burst master for the RTC multiplexed address/data bus: NREG writes or NREG reads per
// start pulse, with address latch, chip-select window, strobe and recovery phases.
module rtc_bus_master
    import rtc_bus_pkg::*;
#(
    parameter int NREG  = DEF_NREG,
    parameter int DW    = DEF_DW,
    parameter int T_AS  = DEF_T_AS,
    parameter int T_AH  = DEF_T_AH,
    parameter int T_PW  = DEF_T_PW,
    parameter int T_REC = DEF_T_REC
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_rnw,
    input  logic [NREG*DW-1:0] i_addr_list,
    input  logic [NREG*DW-1:0] i_wdata_list,
    output logic [NREG*DW-1:0] o_rdata_list,
    output logic               o_busy,
    output logic               o_done,
    rtc_bus_if.master          bus
);
    localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

    state_e             r_state;
    state_e             w_state_nxt;
    strb_t              r_strb;
    logic [DW-1:0]      r_ad_out;
    logic               r_busy;
    logic               r_done;
    logic               r_rnw;
    logic [NREG*DW-1:0] r_addr_sh;
    logic [NREG*DW-1:0] r_wdata_sh;
    logic [NREG*DW-1:0] r_rdata;
    logic [IW-1:0]      r_idx;
    logic               w_last;
    logic               w_zero;
    logic               w_load;
    logic [TMR_W-1:0]   w_load_val;
    logic               w_rnw_eff;
    logic [DW-1:0]      w_addr_cur;

    assign w_last     = (r_idx == IW'(NREG - 1));
    assign w_rnw_eff  = (r_state == S_IDLE) ? i_rnw : r_rnw;
    assign w_addr_cur = (r_state == S_IDLE) ? i_addr_list[DW-1:0] : r_addr_sh[DW-1:0];

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can
        // leave it unassigned and infer a latch.
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (i_start) w_state_nxt = S_AS_HI;
            S_AS_HI:   if (w_zero)  w_state_nxt = S_AS_LO;
            S_AS_LO:   if (w_zero)  w_state_nxt = S_CS_SU;
            S_CS_SU:   if (w_zero)  w_state_nxt = S_STROBE;
            S_STROBE:  if (w_zero)  w_state_nxt = S_CS_HOLD;
            S_CS_HOLD: if (w_zero)  w_state_nxt = S_RECOVER;
            S_RECOVER: if (w_zero)  w_state_nxt = w_last ? S_DONE : S_AS_HI;
            default:                w_state_nxt = S_IDLE;
        endcase
    end

    // Timer is reloaded on every state change with (phase length - 1).
    always_comb begin
        w_load_val = '0;
        case (w_state_nxt)
            S_AS_HI:   w_load_val = TMR_W'(T_AS - 1);
            S_AS_LO:   w_load_val = TMR_W'(T_AH - 1);
            S_STROBE:  w_load_val = TMR_W'(T_PW - 1);
            S_RECOVER: w_load_val = TMR_W'(T_REC - 1);
            default:   w_load_val = '0;
        endcase
    end

    assign w_load = (w_state_nxt != r_state);

    rtc_phase_timer #(.TW(TMR_W)) u_timer (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_load  (w_load),
        .i_value (w_load_val),
        .o_zero  (w_zero)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_strb     <= strobes_for(S_IDLE, 1'b0);
            r_ad_out   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rnw      <= 1'b0;
            r_addr_sh  <= '0;
            r_wdata_sh <= '0;
            r_rdata    <= '0;
            r_idx      <= '0;
        end else begin
            // Pin outputs are registered from the next state so they change with it.
            r_state <= w_state_nxt;
            r_strb  <= strobes_for(w_state_nxt, w_rnw_eff);
            r_busy  <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
            r_done  <= (w_state_nxt == S_DONE);
            case (w_state_nxt)
                S_AS_HI, S_AS_LO:             r_ad_out <= w_addr_cur;
                S_CS_SU, S_STROBE, S_CS_HOLD: r_ad_out <= w_rnw_eff ? '0 : r_wdata_sh[DW-1:0];
                default:                      r_ad_out <= '0;
            endcase

            if (r_state == S_IDLE && i_start) begin
                r_rnw      <= i_rnw;
                r_addr_sh  <= i_addr_list;
                r_wdata_sh <= i_wdata_list;
                r_idx      <= '0;
            end
            if (r_state == S_STROBE && w_zero && r_rnw) begin
                r_rdata[r_idx*DW +: DW] <= bus.ad_in;
            end
            // Slot 0 of the shift registers is always the access in progress.
            if (r_state == S_CS_HOLD && w_zero) begin
                r_addr_sh  <= r_addr_sh >> DW;
                r_wdata_sh <= r_wdata_sh >> DW;
            end
            if (r_state == S_RECOVER && w_zero && !w_last) begin
                r_idx <= r_idx + IW'(1);
            end
        end
    end

    assign bus.ad_out    = r_ad_out;
    assign bus.ad_oe     = r_strb.oe;
    assign bus.ad        = r_strb.ad;
    assign bus.wr        = r_strb.wr;
    assign bus.rd        = r_strb.rd;
    assign bus.cs        = r_strb.cs;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_rdata_list  = r_rdata;
endmodule
